// File: rtl/regin.sv
// Byte-to-word packer: MSB-first bytes form 32-bit words that land in a FWFT buffer.
// Optional REGIN_ECHO_EN adds an echo output holding the last accepted byte.
module regin #(
  parameter int N     = 32,
  parameter int DEPTH = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic [1:0]   byte_idx,
  output logic [3:0]   count,
  output logic         full,
  output logic         ovf
`ifdef REGIN_ECHO_EN
  ,
  output logic [7:0]   echo
`endif
);

  localparam logic [3:0] DEPTH_C  = 4'(DEPTH);
  localparam logic [3:0] PTR_LAST = 4'(DEPTH - 1);

  logic [23:0]  shift_q;
  logic [1:0]   idx_q;
  logic [3:0]   count_q, count_d;
  logic [3:0]   wr_ptr_q, rd_ptr_q;
  logic [3:0]   wr_ptr_d, rd_ptr_d;
  logic         ovf_q;
  logic [N-1:0] mem_q [DEPTH];

  logic         word_done, pop, push_ok, drop, full_w, valid_w;
  logic [N-1:0] new_word;

  assign full_w    = (count_q == DEPTH_C);
  assign valid_w   = (count_q != 4'd0);
  assign word_done = byte_valid && (idx_q == 2'd3);
  assign pop       = valid_w && word_ready;
  // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
  assign push_ok   = word_done && (!full_w || pop);
  assign drop      = word_done && full_w && !pop;
  assign new_word  = {shift_q, byte_in};

  assign wr_ptr_d = (wr_ptr_q == PTR_LAST) ? 4'd0 : wr_ptr_q + 4'd1;
  assign rd_ptr_d = (rd_ptr_q == PTR_LAST) ? 4'd0 : rd_ptr_q + 4'd1;
  assign count_d  = count_q + {3'b000, push_ok} - {3'b000, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      idx_q    <= 2'd0;
      count_q  <= 4'd0;
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      ovf_q    <= 1'b0;
    end else if (clr) begin
      idx_q    <= 2'd0;
      count_q  <= 4'd0;
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (byte_valid) begin
        idx_q <= idx_q + 2'd1;
        if (idx_q != 2'd3) shift_q <= {shift_q[15:0], byte_in};
      end
      if (push_ok) wr_ptr_q <= wr_ptr_d;
      if (pop)     rd_ptr_q <= rd_ptr_d;
      if (drop)    ovf_q    <= 1'b1;
      count_q <= count_d;
    end
  end

  // Buffer storage carries no reset; only the pointers and count define its state.
  always_ff @(posedge clk) begin
    if (!rst && !clr && push_ok) mem_q[wr_ptr_q] <= new_word;
  end

`ifdef REGIN_ECHO_EN
  logic [7:0] echo_q;
  always_ff @(posedge clk) begin
    if (rst || clr)      echo_q <= 8'd0;
    else if (byte_valid) echo_q <= byte_in;
  end
  assign echo = echo_q;
`endif

  assign word_out   = valid_w ? mem_q[rd_ptr_q] : '0;
  assign word_valid = valid_w;
  assign byte_idx   = idx_q;
  assign count      = count_q;
  assign full       = full_w;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_regin.sv
// Directed bench for regin: packing, overflow, full push+pop, clear, drain and reset.
module tb_regin;
  logic        clk;
  logic        rst;
  logic        clr;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [1:0]  byte_idx;
  logic [3:0]  count;
  logic        full;
  logic        ovf;
`ifdef REGIN_ECHO_EN
  logic [7:0]  echo;
`endif

  int errors = 0;
  int checks = 0;

  regin #(.N(32), .DEPTH(11)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .byte_in(byte_in), .byte_valid(byte_valid),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .byte_idx(byte_idx), .count(count), .full(full), .ovf(ovf)
`ifdef REGIN_ECHO_EN
    , .echo(echo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    send_byte(t[31:24]);
    send_byte(t[23:16]);
    send_byte(t[15:8]);
    send_byte(t[7:0]);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_idx"},   32'(byte_idx),   32'd0);
    chk({tag, "_count"}, 32'(count),      32'd0);
    chk({tag, "_valid"}, 32'(word_valid), 32'd0);
    chk({tag, "_full"},  32'(full),       32'd0);
    chk({tag, "_ovf"},   32'(ovf),        32'd0);
  endtask

  initial begin
    logic [31:0] exp_w;
    rst = 1'b1; clr = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; word_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset("rst");
    chk("rst_word", word_out, 32'h0);
`ifdef REGIN_ECHO_EN
    chk("rst_echo", 32'(echo), 32'h0);
`endif

    // First word, byte index stepping
    send_byte(8'h12); chk("idx1", 32'(byte_idx), 32'd1);
    send_byte(8'h34); chk("idx2", 32'(byte_idx), 32'd2);
    send_byte(8'h56); chk("idx3", 32'(byte_idx), 32'd3);
    chk("valid_partial", 32'(word_valid), 32'd0);
    send_byte(8'h78); chk("idx0", 32'(byte_idx), 32'd0);
    chk("w0_word", word_out, 32'h12345678);
    chk("w0_valid", 32'(word_valid), 32'd1);
    chk("w0_count", 32'(count), 32'd1);
`ifdef REGIN_ECHO_EN
    chk("echo78", 32'(echo), 32'h78);
`endif

    // Fill to capacity, then overflow
    for (int i = 1; i <= 10; i++) send_word(32'hA000_0000 | 32'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd11);
    chk("fill_ovf", 32'(ovf), 32'd0);
    send_word(32'hDEAD_BEEF);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd11);
    chk("ovf_head", word_out, 32'h12345678);

    // Clear with a simultaneous byte strobe and pop: both ignored
    byte_in = 8'h55; byte_valid = 1'b1; word_ready = 1'b1; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; byte_valid = 1'b0; word_ready = 1'b0;
    chk_reset("clr");
`ifdef REGIN_ECHO_EN
    chk("clr_echo", 32'(echo), 32'h0);
`endif

    // Full buffer: push and pop in the same cycle
    for (int i = 0; i <= 10; i++) send_word(32'hB000_0000 | 32'(i));
    chk("refill_count", 32'(count), 32'd11);
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    byte_in = 8'hC4; byte_valid = 1'b1; word_ready = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0; word_ready = 1'b0;
    chk("pp_count", 32'(count), 32'd11);
    chk("pp_ovf", 32'(ovf), 32'd0);
    chk("pp_full", 32'(full), 32'd1);
    word_ready = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      exp_w = (i < 11) ? (32'hB000_0000 | 32'(i)) : 32'hC1C2C3C4;
      chk($sformatf("drain%0d_word", i), word_out, exp_w);
      chk($sformatf("drain%0d_count", i), 32'(count), 32'(12 - i));
      @(negedge clk);
    end
    chk("drain_valid", 32'(word_valid), 32'd0);
    chk("drain_count", 32'(count), 32'd0);
    word_ready = 1'b0;

    // Clear discards a partial word
    send_byte(8'hAA); send_byte(8'hBB);
    chk("part_idx", 32'(byte_idx), 32'd2);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("clr_idx", 32'(byte_idx), 32'd0);
    send_word(32'h01020304);
    chk("clr_word", word_out, 32'h01020304);
    chk("clr_word_count", 32'(count), 32'd1);
    word_ready = 1'b1; @(negedge clk); word_ready = 1'b0;
    chk("pop_count", 32'(count), 32'd0);

    // Back-to-back drain of three words
    send_word(32'hD1D1D1D1); send_word(32'hD2D2D2D2); send_word(32'hD3D3D3D3);
    chk("three_count", 32'(count), 32'd3);
    word_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_w = {4{4'hD, 4'(i)}};
      chk($sformatf("b2b%0d_word", i), word_out, exp_w);
      chk($sformatf("b2b%0d_valid", i), 32'(word_valid), 32'd1);
      @(negedge clk);
    end
    chk("b2b_valid", 32'(word_valid), 32'd0);
    chk("b2b_count", 32'(count), 32'd0);
    word_ready = 1'b0;

    // Reset mid-word with words buffered
    send_word(32'hE0E0E0E0); send_word(32'hE1E1E1E1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    chk("pre_rst_count", 32'(count), 32'd2);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk_reset("rst2");
    chk("rst2_word", word_out, 32'h0);
    send_word(32'hF00DCAFE);
    chk("post_rst_word", word_out, 32'hF00DCAFE);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_idx", 32'(byte_idx), 32'd0);
`ifdef REGIN_ECHO_EN
    chk("echoFE", 32'(echo), 32'hFE);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
